// File: rtl/coin_acceptor.sv
// Purpose : synchronise and debounce the nickel/dime chute sensors and emit one
//           clean single-cycle Nin/Din pulse per physical coin (Reject if both).
// Latency : a steady raw level first sampled at edge E1 pulses high after edge
//           E(DEBOUNCE_CYCLES+2); no backpressure, the vending FSM takes every pulse.
//
// Ports:
//   clk          system clock, all state on the rising edge
//   reset        asynchronous, active-high reset
//   nickel_raw   raw nickel chute sensor (asynchronous, bouncy)
//   dime_raw     raw dime chute sensor (asynchronous, bouncy)
//   Nin          registered one-cycle pulse per accepted nickel
//   Din          registered one-cycle pulse per accepted dime
//   Reject       registered one-cycle pulse when both sensors are held together
//   Busy         registered, high whenever the FSM is not in IDLE
//
// Optional build macro COIN_ACCEPTOR_TALLY_EN adds saturating 8-bit event
// counters nickel_tally / dime_tally / reject_tally. Core behaviour is the
// same in both builds.

module coin_acceptor #(
    parameter int DEBOUNCE_CYCLES = 4,   // legal 2..255
    parameter int GAP_CYCLES      = 2    // legal 1..255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       nickel_raw,
    input  logic       dime_raw,
    output logic       Nin,
    output logic       Din,
    output logic       Reject,
    output logic       Busy
`ifdef COIN_ACCEPTOR_TALLY_EN
    ,
    output logic [7:0] nickel_tally,
    output logic [7:0] dime_tally,
    output logic [7:0] reject_tally
`endif
);

    // Terminal counts. The parameter ranges keep both below 255, so the 8-bit
    // counter can never wrap.
    localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

    localparam logic [1:0] CODE_NONE   = 2'b00;
    localparam logic [1:0] CODE_NICKEL = 2'b01;
    localparam logic [1:0] CODE_DIME   = 2'b10;
    localparam logic [1:0] CODE_BOTH   = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        QUAL,
        EMIT,
        RELEASE,
        GAP
    } state_t;

    // ------------------------------------------------------------------
    // Two-flop synchronisers
    // ------------------------------------------------------------------
    logic       nickel_meta;
    logic       nickel_sync;
    logic       dime_meta;
    logic       dime_sync;
    logic [1:0] s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nickel_meta <= 1'b0;
            nickel_sync <= 1'b0;
            dime_meta   <= 1'b0;
            dime_sync   <= 1'b0;
        end else begin
            nickel_meta <= nickel_raw;
            nickel_sync <= nickel_meta;
            dime_meta   <= dime_raw;
            dime_sync   <= dime_meta;
        end
    end

    assign s = {dime_sync, nickel_sync};

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    state_t     state;
    state_t     state_nxt;
    logic [7:0] cnt;
    logic [7:0] cnt_nxt;
    logic [1:0] code;
    logic [1:0] code_nxt;
    logic       nin_nxt;
    logic       din_nxt;
    logic       reject_nxt;
    logic       busy_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= 8'd0;
            code   <= CODE_NONE;
            Nin    <= 1'b0;
            Din    <= 1'b0;
            Reject <= 1'b0;
            Busy   <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            code   <= code_nxt;
            Nin    <= nin_nxt;
            Din    <= din_nxt;
            Reject <= reject_nxt;
            Busy   <= busy_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        code_nxt   = code;
        nin_nxt    = 1'b0;
        din_nxt    = 1'b0;
        reject_nxt = 1'b0;

        case (state)
            IDLE: begin
                // The capturing sample is the first of the DEBOUNCE_CYCLES
                // matching samples, hence cnt starts at 1.
                if (s != CODE_NONE) begin
                    code_nxt  = s;
                    cnt_nxt   = 8'd1;
                    state_nxt = QUAL;
                end
            end

            QUAL: begin
                if (s != code) begin
                    // Any change (bounce, or the other chute joining in)
                    // restarts qualification via IDLE.
                    state_nxt = IDLE;
                    cnt_nxt   = 8'd0;
                end else if (cnt == DEB_LAST) begin
                    state_nxt = EMIT;
                    cnt_nxt   = 8'd0;
                    case (code)
                        CODE_NICKEL: nin_nxt    = 1'b1;
                        CODE_DIME:   din_nxt    = 1'b1;
                        CODE_BOTH:   reject_nxt = 1'b1;
                        default:     ;
                    endcase
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end

            EMIT: begin
                state_nxt = RELEASE;
                cnt_nxt   = 8'd0;
            end

            RELEASE: begin
                // Need DEBOUNCE_CYCLES consecutive idle samples; any activity
                // (bounce or a coin still sitting on the sensor) restarts it.
                if (s != CODE_NONE) begin
                    cnt_nxt = 8'd0;
                end else if (cnt == DEB_LAST) begin
                    state_nxt = GAP;
                    cnt_nxt   = 8'd0;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end

            GAP: begin
                // Inputs are deliberately ignored here.
                if (cnt == GAP_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 8'd0;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end

            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 8'd0;
                code_nxt  = CODE_NONE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

`ifdef COIN_ACCEPTOR_TALLY_EN
    // ------------------------------------------------------------------
    // Saturating event tallies, advanced by the registered pulses
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nickel_tally <= 8'd0;
            dime_tally   <= 8'd0;
            reject_tally <= 8'd0;
        end else begin
            if (Nin && (nickel_tally != 8'hFF)) begin
                nickel_tally <= nickel_tally + 8'd1;
            end
            if (Din && (dime_tally != 8'hFF)) begin
                dime_tally <= dime_tally + 8'd1;
            end
            if (Reject && (reject_tally != 8'hFF)) begin
                reject_tally <= reject_tally + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Purpose : directed self-checking bench for coin_acceptor (default parameters).
// Latency : inputs driven and outputs sampled 1 time unit after each rising edge.
// Flow    : no backpressure; pulses are counted on the falling edge.

module tb_coin_acceptor;

    logic clk;
    logic reset;
    logic nickel_raw;
    logic dime_raw;
    logic Nin;
    logic Din;
    logic Reject;
    logic Busy;
`ifdef COIN_ACCEPTOR_TALLY_EN
    logic [7:0] nickel_tally;
    logic [7:0] dime_tally;
    logic [7:0] reject_tally;
`endif

    coin_acceptor #(
        .DEBOUNCE_CYCLES(4),
        .GAP_CYCLES     (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .nickel_raw  (nickel_raw),
        .dime_raw    (dime_raw),
        .Nin         (Nin),
        .Din         (Din),
        .Reject      (Reject),
        .Busy        (Busy)
`ifdef COIN_ACCEPTOR_TALLY_EN
        ,
        .nickel_tally(nickel_tally),
        .dime_tally  (dime_tally),
        .reject_tally(reject_tally)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse counters and protocol watch (pulses last one full cycle, so each
    // is seen exactly once on the falling edge).
    int n_cnt    = 0;
    int d_cnt    = 0;
    int r_cnt    = 0;
    int viol     = 0;
    int prev_any = 0;

    always @(negedge clk) begin
        int any;
        any = (Nin === 1'b1 || Din === 1'b1 || Reject === 1'b1) ? 1 : 0;
        if (Nin === 1'b1) n_cnt++;
        if (Din === 1'b1) d_cnt++;
        if (Reject === 1'b1) r_cnt++;
        if ((int'(Nin === 1'b1) + int'(Din === 1'b1) + int'(Reject === 1'b1)) > 1) viol++;
        if (any == 1 && prev_any == 1) viol++;
        prev_any = any;
    end

    int nb, db, rb;
    int cents;

    initial begin
        reset      = 1'b1;
        nickel_raw = 1'b0;
        dime_raw   = 1'b0;
        tick();
        tick();
        chk("rst_nin",    Nin,    0);
        chk("rst_din",    Din,    0);
        chk("rst_reject", Reject, 0);
        chk("rst_busy",   Busy,   0);
        reset = 1'b0;
        tick();

        // ---- nickel held 20 cycles: pulse after E6 ----
        nb = n_cnt; db = d_cnt; rb = r_cnt;
        nickel_raw = 1'b1;
        tick(); tick();
        chk("t1_busy_e2", Busy, 0);
        tick();
        chk("t1_busy_e3", Busy, 1);
        tick(); tick();
        chk("t1_nin_e5", Nin, 0);
        tick();
        chk("t1_nin_e6", Nin, 1);
        chk("t1_din_e6", Din, 0);
        chk("t1_rej_e6", Reject, 0);
        tick();
        chk("t1_nin_e7", Nin, 0);
        repeat (13) tick();              // after E20
        nickel_raw = 1'b0;
        repeat (7) tick();               // after E27
        chk("t1_busy_e27", Busy, 1);
        tick();
        chk("t1_busy_e28", Busy, 0);
        chk("t1_nin_count", n_cnt - nb, 1);
        chk("t1_din_count", d_cnt - db, 0);

        // ---- dime glitch of 3 cycles: no pulse ----
        db = d_cnt;
        dime_raw = 1'b1;
        repeat (3) tick();
        dime_raw = 1'b0;
        tick(); tick();                  // after F5
        chk("t2_busy_f5", Busy, 1);
        tick();
        chk("t2_busy_f6", Busy, 0);
        repeat (4) tick();
        chk("t2_din_count", d_cnt - db, 0);

        // ---- dime with bounce during release ----
        db = d_cnt;
        dime_raw = 1'b1;
        repeat (5) tick();
        chk("t3_din_g5", Din, 0);
        tick();
        chk("t3_din_g6", Din, 1);
        dime_raw = 1'b0; tick(); tick();
        dime_raw = 1'b1; tick(); tick();
        dime_raw = 1'b0; tick(); tick();
        dime_raw = 1'b1; tick(); tick();
        dime_raw = 1'b0;                 // after G14, stays low
        repeat (7) tick();               // after G21
        chk("t3_busy_g21", Busy, 1);
        tick();
        chk("t3_busy_g22", Busy, 0);
        chk("t3_din_count", d_cnt - db, 1);

        // ---- both sensors: Reject only ----
        nb = n_cnt; db = d_cnt; rb = r_cnt;
        nickel_raw = 1'b1;
        dime_raw   = 1'b1;
        repeat (6) tick();
        chk("t4_rej_h6", Reject, 1);
        chk("t4_nin_h6", Nin, 0);
        chk("t4_din_h6", Din, 0);
        repeat (4) tick();
        nickel_raw = 1'b0;
        dime_raw   = 1'b0;
        repeat (20) tick();
        chk("t4_busy_end", Busy, 0);
        chk("t4_rej_count", r_cnt - rb, 1);
        chk("t4_nin_count", n_cnt - nb, 0);
        chk("t4_din_count", d_cnt - db, 0);

        // ---- nickel, nickel, dime, dime ----
        nb = n_cnt; db = d_cnt;
        for (int i = 0; i < 4; i++) begin
            if (i < 2) nickel_raw = 1'b1;
            else       dime_raw   = 1'b1;
            repeat (10) tick();
            nickel_raw = 1'b0;
            dime_raw   = 1'b0;
            repeat (10) tick();
        end
        chk("t5_nin_count", n_cnt - nb, 2);
        chk("t5_din_count", d_cnt - db, 2);
        cents = 5 * (n_cnt - nb) + 10 * (d_cnt - db);
        chk("t5_cents", cents, 30);
        chk("t5_dispense", (cents >= 20) ? 1 : 0, 1);
        chk("t5_busy_end", Busy, 0);

        // ---- reset during qualification ----
        nb = n_cnt;
        nickel_raw = 1'b1;
        repeat (4) tick();               // QUAL, cnt=2
        chk("t6_busy_qual", Busy, 1);
        reset      = 1'b1;
        nickel_raw = 1'b0;
        #1;
        chk("t6_nin_rst",  Nin,    0);
        chk("t6_busy_rst", Busy,   0);
        chk("t6_rej_rst",  Reject, 0);
        tick();
        reset = 1'b0;
        repeat (10) tick();
        chk("t6_nin_count", n_cnt - nb, 0);
        chk("t6_busy_end",  Busy, 0);

`ifdef COIN_ACCEPTOR_TALLY_EN
        chk("tally_n_rst", nickel_tally, 0);
        chk("tally_d_rst", dime_tally,   0);
        for (int i = 0; i < 300; i++) begin
            nickel_raw = 1'b1;
            repeat (6) tick();
            nickel_raw = 1'b0;
            repeat (12) tick();
            if (i == 2) chk("tally_n_3", nickel_tally, 3);
        end
        chk("tally_n_sat", nickel_tally, 255);
        chk("tally_d_zero", dime_tally,  0);
        chk("tally_r_zero", reject_tally, 0);
`endif

        chk("pulse_protocol", viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
